// File: rtl/c1541_track_sched_if.sv
// c1541_track_sched_if
//   Groups the drive-logic and SD-loader signals of the 1541 head tracker.
//   slave  : the tracker itself (consumes stepper/motor/pulses, drives requests and head state)
//   master : the environment (drive logic core + SD/track-buffer loader)
//   Signals:
//     stp[1:0]      stepper phase from drive logic
//     mtr           spindle motor on
//     dirty         pulse: track buffer was written
//     img_mounted   pulse: new disk image inserted
//     sd_done       pulse: current SD transfer finished
//     sd_rd, sd_wr  load / save request levels
//     sd_track[5:0] track number for the active request (0 when none)
//     htrack[6:0]   current half-track
//     tr00_sense_n  low when the head is on half-track 0
//     busy          scheduler not idle
interface c1541_track_sched_if;
   logic [1:0] stp;
   logic       mtr;
   logic       dirty;
   logic       img_mounted;
   logic       sd_done;
   logic       sd_rd;
   logic       sd_wr;
   logic [5:0] sd_track;
   logic [6:0] htrack;
   logic       tr00_sense_n;
   logic       busy;

   modport slave (
      input  stp, mtr, dirty, img_mounted, sd_done,
      output sd_rd, sd_wr, sd_track, htrack, tr00_sense_n, busy
   );

   modport master (
      output stp, mtr, dirty, img_mounted, sd_done,
      input  sd_rd, sd_wr, sd_track, htrack, tr00_sense_n, busy
   );
endinterface

// File: rtl/c1541_track_sched.sv
// c1541_track_sched
//   Head-position tracker and track-buffer scheduler for the 1541 drive model.
//   Decodes stepper phases into a half-track position, drives the track-0 sense line,
//   and after the head settles on a new track writes back the previous track (if modified)
//   and loads the new one through the SD-side request lines.
//   Ports:
//     clk32  system clock, posedge
//     reset  asynchronous, active-high
//     bus    c1541_track_sched_if.slave (stepper/motor/pulses in, requests/head state out)
//   Parameters:
//     SETTLE_CYCLES  head-settle delay in clk32 cycles
//     MAX_HTRACK     highest half-track, position saturates there
//     RESET_HTRACK   head position after reset
//   Build option:
//     C1541_SAVE_EN  when defined, modified tracks are written back (SAVE state, sd_wr);
//                    when undefined, dirty is ignored and sd_wr is tied low.
module c1541_track_sched #(
   parameter logic [19:0] SETTLE_CYCLES = 20'd640000,
   parameter logic [6:0]  MAX_HTRACK    = 7'd83,
   parameter logic [6:0]  RESET_HTRACK  = 7'd34
) (
   input logic                    clk32,
   input logic                    reset,
   c1541_track_sched_if.slave     bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAVE   = 2'd2;
   localparam logic [1:0] ST_LOAD   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [1:0]  stp_prev_q;
   logic [6:0]  htrack_q, htrack_d;
   logic        reload_q;
   logic        img_present_q;
   logic        mount_pend_q, mount_pend_d;
   logic        dirty_flag_q;
   logic [5:0]  loaded_q, loaded_d;
   logic [5:0]  lat_q, lat_d;
   logic [19:0] cnt_q, cnt_d;
   logic        sd_rd_q, sd_wr_q, busy_q, tr00_q;
   logic [5:0]  sd_track_q, sd_track_d;

   logic [1:0]  step_diff;
   logic        step_up, step_dn;
   logic [5:0]  target;

   // ---------------- stepper decode ----------------
   always_comb begin
      step_diff = bus.stp - stp_prev_q;
      step_up   = bus.mtr && (step_diff == 2'd1);
      step_dn   = bus.mtr && (step_diff == 2'd3);
      htrack_d  = htrack_q;
      if (step_up && (htrack_q < MAX_HTRACK)) begin
         htrack_d = htrack_q + 7'd1;
      end else if (step_dn && (htrack_q != 7'd0)) begin
         htrack_d = htrack_q - 7'd1;
      end
   end

   assign target = htrack_q[6:1] + 6'd1;

   // ---------------- scheduler FSM ----------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lat_d    = lat_q;
      loaded_d = loaded_q;
      case (state_q)
         ST_IDLE: begin
            if (img_present_q && ((target != loaded_q) || mount_pend_q)) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_CYCLES - 20'd1;
            end
         end
         ST_SETTLE: begin
            // reload_q is one cycle behind the event so that IDLE-entry and in-SETTLE
            // restarts both give the same event-to-request latency.
            if (reload_q) begin
               cnt_d = SETTLE_CYCLES - 20'd1;
            end else if (cnt_q == 20'd0) begin
               if (dirty_flag_q) begin
                  state_d = ST_SAVE;
               end else begin
                  state_d = ST_LOAD;
                  lat_d   = target;
               end
            end else begin
               cnt_d = cnt_q - 20'd1;
            end
         end
         ST_SAVE: begin
            if (bus.sd_done) begin
               state_d = ST_LOAD;
               lat_d   = target;
            end
         end
         ST_LOAD: begin
            if (bus.sd_done) begin
               state_d  = ST_IDLE;
               loaded_d = lat_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mount_pend_d = mount_pend_q;
      if (bus.img_mounted) begin
         mount_pend_d = 1'b1;
      end else if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
         mount_pend_d = 1'b0;
      end
   end

   always_comb begin
      sd_track_d = 6'd0;
      if (state_d == ST_LOAD) begin
         sd_track_d = lat_d;
      end else if (state_d == ST_SAVE) begin
         sd_track_d = loaded_q;
      end
   end

   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         stp_prev_q    <= 2'd0;
         htrack_q      <= RESET_HTRACK;
         reload_q      <= 1'b0;
         img_present_q <= 1'b0;
         mount_pend_q  <= 1'b0;
         loaded_q      <= 6'd0;
         lat_q         <= 6'd0;
         cnt_q         <= 20'd0;
         sd_rd_q       <= 1'b0;
         busy_q        <= 1'b0;
         tr00_q        <= 1'b1;
         sd_track_q    <= 6'd0;
      end else begin
         state_q       <= state_d;
         stp_prev_q    <= bus.stp;
         htrack_q      <= htrack_d;
         reload_q      <= (htrack_d != htrack_q) || bus.img_mounted;
         img_present_q <= img_present_q || bus.img_mounted;
         mount_pend_q  <= mount_pend_d;
         loaded_q      <= loaded_d;
         lat_q         <= lat_d;
         cnt_q         <= cnt_d;
         sd_rd_q       <= (state_d == ST_LOAD);
         busy_q        <= (state_d != ST_IDLE);
         tr00_q        <= (htrack_d != 7'd0);
         sd_track_q    <= sd_track_d;
      end
   end

`ifdef C1541_SAVE_EN
   logic dirty_flag_d;

   always_comb begin
      dirty_flag_d = dirty_flag_q;
      if ((state_q == ST_SAVE) && bus.sd_done) begin
         dirty_flag_d = 1'b0;
      end else if (bus.img_mounted && (state_q != ST_SAVE)) begin
         dirty_flag_d = 1'b0;
      end
      // A write arriving with the clear must survive, or its data would be lost.
      if (bus.dirty) begin
         dirty_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         dirty_flag_q <= 1'b0;
         sd_wr_q      <= 1'b0;
      end else begin
         dirty_flag_q <= dirty_flag_d;
         sd_wr_q      <= (state_d == ST_SAVE);
      end
   end
`else
   logic unused_dirty;
   assign unused_dirty = bus.dirty;
   assign dirty_flag_q = 1'b0;
   assign sd_wr_q      = 1'b0;
`endif

   assign bus.sd_rd        = sd_rd_q;
   assign bus.sd_wr        = sd_wr_q;
   assign bus.sd_track     = sd_track_q;
   assign bus.htrack       = htrack_q;
   assign bus.tr00_sense_n = tr00_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_c1541_track_sched.sv
module tb_c1541_track_sched;
   localparam int S = 32;

   logic clk32 = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   c1541_track_sched_if bus ();

   c1541_track_sched #(
      .SETTLE_CYCLES(20'(S)),
      .MAX_HTRACK   (7'd83),
      .RESET_HTRACK (7'd34)
   ) dut (
      .clk32(clk32),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk32 = ~clk32;

   typedef struct {
      logic       mtr;
      logic [1:0] stp;
      logic [6:0] exp_ht;
      logic       exp_tr00;
   } step_vec_t;

   step_vec_t vt [11];

   task automatic tick();
      @(posedge clk32);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.stp         = 2'd0;
      bus.mtr         = 1'b0;
      bus.dirty       = 1'b0;
      bus.img_mounted = 1'b0;
      bus.sd_done     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_mount();
      bus.img_mounted = 1'b1;
      tick();
      bus.img_mounted = 1'b0;
   endtask

   task automatic pulse_done();
      bus.sd_done = 1'b1;
      tick();
      bus.sd_done = 1'b0;
   endtask

   task automatic pulse_dirty();
      bus.dirty = 1'b1;
      tick();
      bus.dirty = 1'b0;
   endtask

   task automatic step(input logic [1:0] s);
      bus.stp = s;
      tick();
   endtask

   // Cycles until a request appears, bounded.
   task automatic wait_req(output int n);
      n = 0;
      while (!(bus.sd_rd || bus.sd_wr) && (n < 4 * S)) begin
         tick();
         n++;
      end
   endtask

   task automatic mount_and_load();
      int n;
      pulse_mount();
      wait_req(n);
      chk("initial_load_latency", n, S + 1);
      pulse_done();
   endtask

   initial begin
      int         n;
      logic       seen;
      logic [1:0] s;

      vt[0]  = '{1'b0, 2'd1, 7'd34, 1'b1};
      vt[1]  = '{1'b0, 2'd2, 7'd34, 1'b1};
      vt[2]  = '{1'b1, 2'd0, 7'd34, 1'b1};
      vt[3]  = '{1'b1, 2'd1, 7'd35, 1'b1};
      vt[4]  = '{1'b1, 2'd1, 7'd35, 1'b1};
      vt[5]  = '{1'b1, 2'd0, 7'd34, 1'b1};
      vt[6]  = '{1'b1, 2'd3, 7'd33, 1'b1};
      vt[7]  = '{1'b1, 2'd2, 7'd32, 1'b1};
      vt[8]  = '{1'b1, 2'd0, 7'd32, 1'b1};
      vt[9]  = '{1'b0, 2'd3, 7'd32, 1'b1};
      vt[10] = '{1'b1, 2'd0, 7'd33, 1'b1};

      // ---- reset state and quiet idle ----
      do_reset();
      chk("rst_htrack", bus.htrack, 34);
      chk("rst_tr00", bus.tr00_sense_n, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sd_rd", bus.sd_rd, 0);
      chk("rst_sd_wr", bus.sd_wr, 0);
      chk("rst_sd_track", bus.sd_track, 0);
      seen = 1'b0;
      repeat (10 * S) begin
         tick();
         seen = seen | bus.sd_rd | bus.sd_wr | bus.busy;
      end
      chk("no_mount_no_request", seen, 0);

      // ---- stepper decode table (no image, so no transfers) ----
      for (int i = 0; i < 11; i++) begin
         bus.mtr = vt[i].mtr;
         step(vt[i].stp);
         chk($sformatf("vec%0d_htrack", i), bus.htrack, vt[i].exp_ht);
         chk($sformatf("vec%0d_tr00", i), bus.tr00_sense_n, vt[i].exp_tr00);
      end
      chk("no_img_idle", bus.busy, 0);

      // step out to half-track 1, then two more step-outs: 0 then saturate
      s = 2'd0;
      repeat (32) begin
         s = s - 2'd1;
         step(s);
      end
      chk("at_ht1", bus.htrack, 1);
      chk("at_ht1_tr00", bus.tr00_sense_n, 1);
      s = s - 2'd1;
      step(s);
      chk("out1_ht", bus.htrack, 0);
      chk("out1_tr00", bus.tr00_sense_n, 0);
      s = s - 2'd1;
      step(s);
      chk("out2_sat_ht", bus.htrack, 0);
      chk("out2_sat_tr00", bus.tr00_sense_n, 0);
      s = s + 2'd1;
      step(s);
      chk("in_from0_ht", bus.htrack, 1);
      chk("in_from0_tr00", bus.tr00_sense_n, 1);
      repeat (90) begin
         s = s + 2'd1;
         step(s);
      end
      chk("sat_max_ht", bus.htrack, 83);

      // ---- mount, load, steps ----
      do_reset();
      pulse_mount();
      wait_req(n);
      chk("mount_latency", n, S + 1);
      chk("mount_sd_rd", bus.sd_rd, 1);
      chk("mount_sd_track", bus.sd_track, 18);
      chk("mount_sd_wr", bus.sd_wr, 0);
      chk("mount_busy", bus.busy, 1);
      pulse_done();
      chk("done_sd_rd", bus.sd_rd, 0);
      chk("done_sd_track", bus.sd_track, 0);
      tick();
      chk("done_busy", bus.busy, 0);
      pulse_done();
      chk("idle_done_ignored", bus.busy, 0);

      bus.mtr = 1'b1;
      seen = 1'b0;
      step(2'd1);
      chk("step_ht35", bus.htrack, 35);
      repeat (9) begin
         tick();
         seen = seen | bus.sd_rd | bus.sd_wr;
      end
      step(2'd2);
      chk("step_ht36", bus.htrack, 36);
      repeat (9) begin
         tick();
         seen = seen | bus.sd_rd | bus.sd_wr;
      end
      step(2'd3);
      chk("step_ht37", bus.htrack, 37);
      chk("no_early_request", seen, 0);
      wait_req(n);
      chk("step_latency", n, S + 1);
      chk("step_sd_rd", bus.sd_rd, 1);
      chk("step_sd_track", bus.sd_track, 19);
      pulse_done();
      chk("step_done_rd", bus.sd_rd, 0);
      tick();
      chk("step_done_busy", bus.busy, 0);

      // ---- write-back path ----
      do_reset();
      mount_and_load();
      bus.mtr = 1'b1;
      pulse_dirty();
      step(2'd1);
      step(2'd2);
      wait_req(n);
      chk("save_latency", n, S + 1);
`ifdef C1541_SAVE_EN
      chk("save_sd_wr", bus.sd_wr, 1);
      chk("save_sd_rd", bus.sd_rd, 0);
      chk("save_sd_track", bus.sd_track, 18);
      pulse_done();
      chk("s2l_sd_wr", bus.sd_wr, 0);
      chk("s2l_sd_rd", bus.sd_rd, 1);
      chk("s2l_sd_track", bus.sd_track, 19);
      pulse_done();
      chk("s2l_done_rd", bus.sd_rd, 0);
      // dirty coincident with sd_done in SAVE keeps the flag
      pulse_dirty();
      step(2'd3);
      step(2'd0);
      wait_req(n);
      chk("save2_sd_wr", bus.sd_wr, 1);
      chk("save2_sd_track", bus.sd_track, 19);
      bus.dirty   = 1'b1;
      bus.sd_done = 1'b1;
      tick();
      bus.dirty   = 1'b0;
      bus.sd_done = 1'b0;
      chk("save2_load_track", bus.sd_track, 20);
      chk("save2_load_rd", bus.sd_rd, 1);
      pulse_done();
      step(2'd1);
      step(2'd2);
      wait_req(n);
      chk("kept_dirty_sd_wr", bus.sd_wr, 1);
      chk("kept_dirty_track", bus.sd_track, 20);
      pulse_done();
      pulse_done();
`else
      chk("nosave_sd_rd", bus.sd_rd, 1);
      chk("nosave_sd_wr", bus.sd_wr, 0);
      chk("nosave_sd_track", bus.sd_track, 19);
      pulse_done();
      chk("nosave_done_rd", bus.sd_rd, 0);
`endif
      tick();
      chk("wb_end_busy", bus.busy, 0);

      // ---- new image during LOAD ----
      do_reset();
      pulse_mount();
      wait_req(n);
      chk("ml_first_rd", bus.sd_rd, 1);
      pulse_mount();
      chk("ml_still_rd", bus.sd_rd, 1);
      pulse_done();
      chk("ml_done_rd", bus.sd_rd, 0);
      wait_req(n);
      chk("ml_reload_latency", n, S + 1);
      chk("ml_reload_rd", bus.sd_rd, 1);
      chk("ml_reload_track", bus.sd_track, 18);
      pulse_done();
      tick();
      chk("ml_end_busy", bus.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
